// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: widths, requester
// encoding and the address legality check.
package mem_port_arbiter_pkg;

    localparam int unsigned ISA_WIDTH      = 32;
    localparam int unsigned DW_DEFAULT     = 32;
    localparam int unsigned MEM_AW_DEFAULT = 14;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LDR = 1'b1
    } requester_e;

    // An access is illegal when it is not word aligned or falls outside the RAM.
    function automatic logic addr_bad(input logic [ISA_WIDTH-1:0] addr,
                                      input int unsigned          aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted last.
module mem_port_arbiter_rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  requester_e last_i,
    output logic [1:0] gnt_o,
    output requester_e winner_o
);

    always_comb begin
        gnt_o    = '0;
        winner_o = last_i;
        case (req_i)
            2'b01: begin
                gnt_o    = 2'b01;
                winner_o = REQ_CPU;
            end
            2'b10: begin
                gnt_o    = 2'b10;
                winner_o = REQ_LDR;
            end
            2'b11: begin
                if (last_i == REQ_LDR) begin
                    gnt_o    = 2'b01;
                    winner_o = REQ_CPU;
                end else begin
                    gnt_o    = 2'b10;
                    winner_o = REQ_LDR;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU and program loader onto one synchronous data RAM port with a
// two-stage pipeline: registered memory command, then routed read data.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AW = MEM_AW_DEFAULT,
    parameter int unsigned DW     = DW_DEFAULT
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 ldr_lock,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ISA_WIDTH-1:0] cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    input  logic                 ldr_req,
    input  logic                 ldr_we,
    input  logic [ISA_WIDTH-1:0] ldr_addr,
    input  logic [DW-1:0]        ldr_wdata,
    output logic                 cpu_gnt,
    output logic                 ldr_gnt,
    output logic                 cpu_rvalid,
    output logic                 ldr_rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 cpu_err,
    output logic                 ldr_err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    logic [1:0]           req_vec;
    logic [1:0]           arb_gnt;
    logic [1:0]           gnt;
    logic                 gnt_any;
    requester_e           winner;

    logic                 sel_we;
    logic [ISA_WIDTH-1:0] sel_addr;
    logic [DW-1:0]        sel_wdata;
    logic                 sel_bad;
    logic                 access_ok;

    requester_e           last_q,      last_d;
    logic                 mem_en_q,    mem_en_d;
    logic                 mem_we_q,    mem_we_d;
    logic [MEM_AW-1:0]    mem_addr_q,  mem_addr_d;
    logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
    requester_e           s1_owner_q,  s1_owner_d;
    logic                 s1_rd_q,     s1_rd_d;
    logic                 s1_err_q,    s1_err_d;
    requester_e           s2_owner_q,  s2_owner_d;
    logic                 s2_rd_q,     s2_rd_d;
    logic [DW-1:0]        rdata_q;

    assign req_vec = {ldr_req, cpu_req & ~ldr_lock};

    mem_port_arbiter_rr_arb2 u_rr (
        .req_i    (req_vec),
        .last_i   (last_q),
        .gnt_o    (arb_gnt),
        .winner_o (winner)
    );

    // Grants are combinational, so they must be masked while reset is held.
    assign gnt     = arb_gnt & {2{rst}};
    assign gnt_any = |gnt;
    assign cpu_gnt = gnt[0];
    assign ldr_gnt = gnt[1];

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == REQ_LDR) begin
            sel_we    = ldr_we;
            sel_addr  = ldr_addr;
            sel_wdata = ldr_wdata;
        end
    end

    assign sel_bad   = addr_bad(sel_addr, MEM_AW);
    assign access_ok = gnt_any & ~sel_bad;

    always_comb begin
        last_d      = gnt_any ? winner : last_q;
        mem_en_d    = access_ok;
        mem_we_d    = access_ok & sel_we;
        mem_addr_d  = access_ok ? sel_addr[MEM_AW+1:2] : mem_addr_q;
        mem_wdata_d = access_ok ? sel_wdata : mem_wdata_q;
        s1_owner_d  = gnt_any ? winner : s1_owner_q;
        s1_rd_d     = access_ok & ~sel_we;
        s1_err_d    = gnt_any & sel_bad;
        s2_owner_d  = s1_owner_q;
        s2_rd_d     = s1_rd_q;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            last_q      <= REQ_LDR;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            s1_owner_q  <= REQ_CPU;
            s1_rd_q     <= 1'b0;
            s1_err_q    <= 1'b0;
            s2_owner_q  <= REQ_CPU;
            s2_rd_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            s1_owner_q  <= s1_owner_d;
            s1_rd_q     <= s1_rd_d;
            s1_err_q    <= s1_err_d;
            s2_owner_q  <= s2_owner_d;
            s2_rd_q     <= s2_rd_d;
            rdata_q     <= rdata;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign cpu_err    = s1_err_q & (s1_owner_q == REQ_CPU);
    assign ldr_err    = s1_err_q & (s1_owner_q == REQ_LDR);
    assign cpu_rvalid = s2_rd_q & (s2_owner_q == REQ_CPU);
    assign ldr_rvalid = s2_rd_q & (s2_owner_q == REQ_LDR);

    // RAM output passes straight through in the rvalid cycle and is held after.
    assign rdata = s2_rd_q ? mem_rdata : rdata_q;

endmodule
